vdp_cpu_bridge: RTL and testbench
=================================

// Module: vdp_cpu_bridge
// PURPOSE
//  CPU-side front end of the VDP. Sits directly upstream of vdp99.
//  Samples the asynchronous Z8S180 I/O strobes in the pxclk domain, filters out glitches, and captures
//  the address bit and the write data. It then issues one-cycle vdp_wr_tick / vdp_rd_tick pulses with
//  a stable mode and din. Read data is latched, and the CPU is held in wait until that data is valid.
// PARAMETERS
//  SYNC_STAGES  2  flip-flop synchronizer depth on each strobe (>=2)
//  FILTER       2  number of consecutive equal synced samples needed to accept an assert or a release (>=1)
// PORTS
//  pxclk         in   1  pixel clock (25MHz); the only clock
//  reset_n       in   1  synchronous, active-low reset
//  cpu_cs_n      in   1  async; decoded VDP port select (IORQ already qualified)
//  cpu_rd_n      in   1  async; CPU read strobe
//  cpu_wr_n      in   1  async; CPU write strobe
//  cpu_a0        in   1  async; 0=VRAM data port, 1=control/status port
//  cpu_d_in      in   8  async; CPU data bus during writes
//  cpu_d_out     out  8  latched read data, for the top-level tristate
//  cpu_d_oe      out  1  drive enable = ~cpu_cs_n & ~cpu_rd_n (combinational)
//  cpu_wait_n    out  1  CPU WAIT, active low
//  vdp_wr_tick   out  1  one-pxclk write pulse to vdp99
//  vdp_rd_tick   out  1  one-pxclk read pulse to vdp99
//  vdp_mode      out  1  captured cpu_a0; valid during both ticks
//  vdp_din       out  8  captured cpu_d_in; valid during vdp_wr_tick
//  vdp_dout      in   8  vdp99 read data; valid during vdp_rd_tick
// BEHAVIOUR
//  - Raw strobes: rs = ~cs_n & ~rd_n, ws = ~cs_n & ~wr_n. Each passes through a SYNC_STAGES chain
//    whose flops reset to 0.
//  - Qualification:
//    - q_on: the last FILTER synced samples are all 1.
//    - q_off: the last FILTER synced samples are all 0.
//    - Sample history is kept in a register; the test is combinational on it.
//  - FSM states: IDLE, WR, RD, DONE. Reset forces state=DONE.
//  - IDLE:
//    - ws q_on and rs not q_on: capture cpu_a0 -> vdp_mode and cpu_d_in -> vdp_din; go to WR.
//    - rs q_on and ws not q_on: capture cpu_a0 -> vdp_mode; go to RD.
//    - both q_on (illegal): no capture, no tick; go to DONE.
//  - WR: vdp_wr_tick=1 for this one cycle; go to DONE.
//  - RD: vdp_rd_tick=1 for this one cycle; rdata <= vdp_dout at the closing edge; go to DONE.
//  - DONE: stay until both rs and ws are q_off; then go to IDLE. Exactly one tick per CPU strobe.
//  - rd_done flag:
//    - Set on every entry to DONE, and by reset.
//    - Cleared on entry to IDLE.
//    - cpu_wait_n = ~(rs_raw & ~rd_done), combinational.
//  - Latency: e0 is the first edge that samples the raw strobe asserted. The tick is high in the cycle
//    after edge e0+SYNC_STAGES+FILTER-1 (e0+3 with the defaults).
//  - Read timing: cpu_wait_n releases at the edge that ends RD. cpu_d_out = rdata holds until the next read.
//  - Data/address are sampled directly from the async pins at the IDLE->WR/RD edge. They have already
//    been stable for SYNC_STAGES+FILTER-1 cycles, so no extra synchronization is needed.
//  - vdp_mode and vdp_din hold their captured values until the next capture.
//    vdp_rd_tick and vdp_wr_tick are never high together.
//  - Reset values:
//    - vdp_wr_tick=0, vdp_rd_tick=0, vdp_mode=0, vdp_din=8'h00.
//    - rdata/cpu_d_out=8'h00, rd_done=1, cpu_wait_n=1, state=DONE.
//  - Reset mid-operation: starting in DONE means a strobe that is still held after reset produces no
//    tick until it is released (q_off) and asserted again. WAIT is never stuck low.
//  - Strobe pulses shorter than FILTER synced samples never produce a tick.
//  - Release gaps shorter than FILTER samples are treated as continuous assertion.
// TESTING
//  - Write control: cs_n=0, wr_n=0, a0=1, d=0x87 held 10 clks -> exactly one vdp_wr_tick, in the cycle
//    after e0+3, with vdp_mode=1 and vdp_din=0x87; no second tick while held.
//  - VRAM read: cs_n=0, rd_n=0, a0=0, vdp_dout=0x5A during the tick -> cpu_wait_n low from strobe
//    assert until the edge after vdp_rd_tick; then cpu_d_out=0x5A; cpu_d_oe high only while the
//    strobe is active.
//  - Glitch: a 1-cycle wr_n=0 pulse (FILTER=2) -> no tick, and the FSM stays in IDLE.
//  - Back-to-back: two writes 0x11 then 0x22 separated by 3 clks of release -> two wr_ticks carrying
//    0x11 then 0x22. With a 1-clk release gap -> one tick only.
//  - Illegal: rd_n=0 and wr_n=0 together for 8 clks -> no ticks; cpu_wait_n returns high once DONE
//    is entered.
//  - Reset mid-read: reset_n=0 for 1 clk while a read is held -> cpu_wait_n=1, no rd_tick; release
//    then re-assert the read -> a normal read completes.

Source files
------------

// File: rtl/vdp_cpu_bridge.sv
// CPU strobe front end for vdp99: syncs/filters Z8S180 strobes, issues one tick per access (e0+SYNC_STAGES+FILTER-1).
// No downstream backpressure; the CPU is stalled via cpu_wait_n until read data is latched.
module vdp_cpu_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 2
) (
  input  logic       pxclk,
  input  logic       reset_n,
  input  logic       cpu_cs_n,
  input  logic       cpu_rd_n,
  input  logic       cpu_wr_n,
  input  logic       cpu_a0,
  input  logic [7:0] cpu_d_in,
  output logic [7:0] cpu_d_out,
  output logic       cpu_d_oe,
  output logic       cpu_wait_n,
  output logic       vdp_wr_tick,
  output logic       vdp_rd_tick,
  output logic       vdp_mode,
  output logic [7:0] vdp_din,
  input  logic [7:0] vdp_dout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int L  = SYNC_STAGES + FILTER - 1;
  localparam int CW = $clog2(L + 1);

  logic              w_rs_raw;
  logic              w_ws_raw;
  logic [L-1:0]      r_rs_sh;
  logic [L-1:0]      r_ws_sh;
  logic [CW-1:0]     r_fill;
  logic              w_primed;
  logic [FILTER-1:0] w_rs_win;
  logic [FILTER-1:0] w_ws_win;
  logic              w_rs_on;
  logic              w_ws_on;
  logic              w_rs_off;
  logic              w_ws_off;
  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic              r_rd_done;
  logic              r_mode;
  logic [7:0]        r_din;
  logic [7:0]        r_rdata;

  assign w_rs_raw = ~cpu_cs_n & ~cpu_rd_n;
  assign w_ws_raw = ~cpu_cs_n & ~cpu_wr_n;

  // Synchronizer and filter history share one shift chain; the top FILTER bits are the synced samples.
  always_ff @(posedge pxclk) begin
    if (!reset_n) begin
      r_rs_sh <= '0;
      r_ws_sh <= '0;
      r_fill  <= '0;
    end else begin
      r_rs_sh <= {r_rs_sh[L-2:0], w_rs_raw};
      r_ws_sh <= {r_ws_sh[L-2:0], w_ws_raw};
      if (!w_primed)
        r_fill <= r_fill + 1'b1;
    end
  end

  // Reset-cleared zeros are not real samples, so a release is only believed once the chain has refilled.
  assign w_primed = (r_fill == CW'(L));
  assign w_rs_win = r_rs_sh[L-1 -: FILTER];
  assign w_ws_win = r_ws_sh[L-1 -: FILTER];
  assign w_rs_on  = &w_rs_win;
  assign w_ws_on  = &w_ws_win;
  assign w_rs_off = w_primed & ~|w_rs_win;
  assign w_ws_off = w_primed & ~|w_ws_win;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_ws_on && !w_rs_on)
          w_next = S_WR;
        else if (w_rs_on && !w_ws_on)
          w_next = S_RD;
        else if (w_rs_on && w_ws_on)
          w_next = S_DONE;
      end
      S_WR, S_RD: w_next = S_DONE;
      default: begin
        if (w_rs_off && w_ws_off)
          w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge pxclk) begin
    if (!reset_n) begin
      r_state   <= S_DONE;
      r_rd_done <= 1'b1;
      r_mode    <= 1'b0;
      r_din     <= 8'h00;
      r_rdata   <= 8'h00;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_next == S_WR) begin
        r_mode <= cpu_a0;
        r_din  <= cpu_d_in;
      end
      if (r_state == S_IDLE && w_next == S_RD)
        r_mode <= cpu_a0;
      if (r_state == S_RD)
        r_rdata <= vdp_dout;
      if (w_next == S_DONE && r_state != S_DONE)
        r_rd_done <= 1'b1;
      else if (w_next == S_IDLE && r_state != S_IDLE)
        r_rd_done <= 1'b0;
    end
  end

  assign vdp_wr_tick = (r_state == S_WR);
  assign vdp_rd_tick = (r_state == S_RD);
  assign vdp_mode    = r_mode;
  assign vdp_din     = r_din;
  assign cpu_d_out   = r_rdata;
  assign cpu_d_oe    = ~cpu_cs_n & ~cpu_rd_n;
  assign cpu_wait_n  = ~(w_rs_raw & ~r_rd_done);

endmodule

// File: tb/tb_vdp_cpu_bridge.sv
// Directed bench for vdp_cpu_bridge with default parameters (tick observed 4 clocks after strobe assert).
module tb_vdp_cpu_bridge;

  logic       pxclk = 1'b0;
  logic       reset_n;
  logic       cpu_cs_n;
  logic       cpu_rd_n;
  logic       cpu_wr_n;
  logic       cpu_a0;
  logic [7:0] cpu_d_in;
  logic [7:0] cpu_d_out;
  logic       cpu_d_oe;
  logic       cpu_wait_n;
  logic       vdp_wr_tick;
  logic       vdp_rd_tick;
  logic       vdp_mode;
  logic [7:0] vdp_din;
  logic [7:0] vdp_dout;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt, rd_cnt, both_cnt, wait_lo, wr_pos, rd_pos, cyc;
  logic [7:0] din_log [0:3];
  logic       mode_at_tick;

  always #5 pxclk = ~pxclk;

  vdp_cpu_bridge dut (
    .pxclk       (pxclk),
    .reset_n     (reset_n),
    .cpu_cs_n    (cpu_cs_n),
    .cpu_rd_n    (cpu_rd_n),
    .cpu_wr_n    (cpu_wr_n),
    .cpu_a0      (cpu_a0),
    .cpu_d_in    (cpu_d_in),
    .cpu_d_out   (cpu_d_out),
    .cpu_d_oe    (cpu_d_oe),
    .cpu_wait_n  (cpu_wait_n),
    .vdp_wr_tick (vdp_wr_tick),
    .vdp_rd_tick (vdp_rd_tick),
    .vdp_mode    (vdp_mode),
    .vdp_din     (vdp_din),
    .vdp_dout    (vdp_dout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    wr_cnt = 0; rd_cnt = 0; both_cnt = 0; wait_lo = 0;
    wr_pos = 0; rd_pos = 0; cyc = 0; mode_at_tick = 1'b0;
    for (int k = 0; k < 4; k++) din_log[k] = 8'h00;
  endtask

  // Advance n clocks, sampling 1 ns after each rising edge.
  task automatic obs(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge pxclk);
      #1;
      cyc++;
      if (vdp_wr_tick) begin
        if (wr_cnt < 4) din_log[wr_cnt] = vdp_din;
        wr_cnt++;
        wr_pos = cyc;
        mode_at_tick = vdp_mode;
      end
      if (vdp_rd_tick) begin
        rd_cnt++;
        rd_pos = cyc;
        mode_at_tick = vdp_mode;
      end
      if (vdp_wr_tick && vdp_rd_tick) both_cnt++;
      if (!cpu_wait_n) wait_lo++;
    end
  endtask

  task automatic idle_pins();
    cpu_cs_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; idle_pins(); cpu_a0 = 1'b0; cpu_d_in = 8'h00; vdp_dout = 8'h00;
    clr();
    obs(2);
    chk("rst_wr_tick", vdp_wr_tick, 0);
    chk("rst_rd_tick", vdp_rd_tick, 0);
    chk("rst_mode", vdp_mode, 0);
    chk("rst_din", vdp_din, 8'h00);
    chk("rst_dout", cpu_d_out, 8'h00);
    chk("rst_wait", cpu_wait_n, 1);
    chk("rst_state", dut.r_state, 2'd3);
    reset_n = 1'b1;
    obs(6);
    chk("idle_after_rst", dut.r_state, 2'd0);

    // Control write, held 10 clocks
    clr();
    cpu_cs_n = 1'b0; cpu_wr_n = 1'b0; cpu_a0 = 1'b1; cpu_d_in = 8'h87;
    obs(10);
    chk("wr_count", wr_cnt, 1);
    chk("wr_latency", wr_pos, 4);
    chk("wr_mode", mode_at_tick, 1);
    chk("wr_din", din_log[0], 8'h87);
    chk("wr_no_rd", rd_cnt, 0);
    chk("wr_wait", wait_lo, 0);
    idle_pins(); cpu_d_in = 8'h00;
    obs(6);
    chk("wr_din_hold", vdp_din, 8'h87);

    // VRAM read; vdp_dout shows 5A only around the tick
    clr();
    vdp_dout = 8'hC3;
    cpu_cs_n = 1'b0; cpu_rd_n = 1'b0; cpu_a0 = 1'b0;
    #1;
    chk("rd_wait_immediate", cpu_wait_n, 0);
    chk("rd_oe_on", cpu_d_oe, 1);
    obs(3);
    vdp_dout = 8'h5A;
    obs(2);
    vdp_dout = 8'hC3;
    obs(5);
    chk("rd_count", rd_cnt, 1);
    chk("rd_latency", rd_pos, 4);
    chk("rd_mode", mode_at_tick, 0);
    chk("rd_wait_cycles", wait_lo, 4);
    chk("rd_wait_released", cpu_wait_n, 1);
    chk("rd_data", cpu_d_out, 8'h5A);
    chk("rd_no_wr", wr_cnt, 0);
    idle_pins();
    #1;
    chk("rd_oe_off", cpu_d_oe, 0);
    obs(6);
    chk("rd_data_hold", cpu_d_out, 8'h5A);

    // One-clock write glitch
    clr();
    cpu_cs_n = 1'b0; cpu_wr_n = 1'b0; cpu_d_in = 8'hEE;
    obs(1);
    idle_pins();
    obs(8);
    chk("glitch_ticks", wr_cnt + rd_cnt, 0);
    chk("glitch_state", dut.r_state, 2'd0);

    // Back-to-back writes with a 3-clock release gap
    clr();
    cpu_cs_n = 1'b0; cpu_wr_n = 1'b0; cpu_d_in = 8'h11;
    obs(6);
    idle_pins();
    obs(3);
    cpu_cs_n = 1'b0; cpu_wr_n = 1'b0; cpu_d_in = 8'h22;
    obs(6);
    idle_pins();
    obs(6);
    chk("b2b_count", wr_cnt, 2);
    chk("b2b_first", din_log[0], 8'h11);
    chk("b2b_second", din_log[1], 8'h22);

    // 1-clock release gap merges into one access
    clr();
    cpu_cs_n = 1'b0; cpu_wr_n = 1'b0; cpu_d_in = 8'h33;
    obs(6);
    idle_pins();
    obs(1);
    cpu_cs_n = 1'b0; cpu_wr_n = 1'b0; cpu_d_in = 8'h44;
    obs(6);
    idle_pins();
    obs(6);
    chk("gap1_count", wr_cnt, 1);
    chk("gap1_din", din_log[0], 8'h33);

    // Illegal simultaneous read and write
    clr();
    cpu_cs_n = 1'b0; cpu_rd_n = 1'b0; cpu_wr_n = 1'b0;
    obs(8);
    chk("illegal_ticks", wr_cnt + rd_cnt, 0);
    chk("illegal_wait_cycles", wait_lo, 3);
    chk("illegal_wait_end", cpu_wait_n, 1);
    idle_pins();
    obs(6);

    // Reset during a held read
    clr();
    vdp_dout = 8'h77;
    cpu_cs_n = 1'b0; cpu_rd_n = 1'b0; cpu_a0 = 1'b1;
    obs(2);
    reset_n = 1'b0;
    obs(1);
    reset_n = 1'b1;
    #1;
    chk("rstmid_wait", cpu_wait_n, 1);
    clr();
    obs(8);
    chk("rstmid_no_tick", rd_cnt, 0);
    chk("rstmid_wait_held", wait_lo, 0);
    idle_pins();
    obs(6);
    cpu_cs_n = 1'b0; cpu_rd_n = 1'b0;
    obs(8);
    chk("rstmid_reread", rd_cnt, 1);
    chk("rstmid_data", cpu_d_out, 8'h77);
    chk("rstmid_mode", mode_at_tick, 1);
    idle_pins();
    obs(4);

    chk("never_both_ticks", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
